// File: rtl/rca_seq_ctrl_if.sv
// Start/busy/done handshake bundle between a requesting datapath and rca_seq_ctrl.
// The sub signal exists only when RCA_SEQ_SUB_EN is defined.
interface rca_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef RCA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;

  modport master (
`ifdef RCA_SEQ_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum
  );

  modport slave (
`ifdef RCA_SEQ_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one shared 4-bit ripple-carry adder.
// Optional subtract mode is enabled with the RCA_SEQ_SUB_EN macro.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sum holds the last result
// RUN   | one nibble per clock through the RCA, carry kept in a register
// DONE  | one-cycle done pulse, full result valid in sum
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  rca_seq_ctrl_if.slave       bus
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [IDXW-1:0]       idx;
  logic                  carry;
  logic [NIB-1:0][3:0]   a_reg;
  logic [NIB-1:0][3:0]   b_reg;
  logic [NIB-1:0][3:0]   sum_nib;
  logic                  sum_msb;
  logic                  busy_q;
  logic                  done_q;
  logic                  sub_req;

`ifdef RCA_SEQ_SUB_EN
  assign sub_req = bus.sub;
`else
  assign sub_req = 1'b0;
`endif

  // The single shared 4-bit ripple-carry adder.
  logic [3:0] rca_a;
  logic [3:0] rca_b;
  logic [3:0] rca_s;
  logic [4:0] rca_c;

  assign rca_a    = a_reg[idx];
  assign rca_b    = b_reg[idx];
  assign rca_c[0] = carry;

  for (genvar i = 0; i < 4; i++) begin : g_rca
    assign rca_s[i]   = rca_a[i] ^ rca_b[i] ^ rca_c[i];
    assign rca_c[i+1] = (rca_a[i] & rca_b[i]) | (rca_c[i] & (rca_a[i] ^ rca_b[i]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_nib <= '0;
      sum_msb <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.a;
            // Subtract is a + ~b + 1, so the inversion and forced carry happen at capture.
            b_reg   <= sub_req ? ~bus.b : bus.b;
            carry   <= sub_req ? 1'b1 : bus.cin;
            idx     <= '0;
            sum_nib <= '0;
            sum_msb <= 1'b0;
            busy_q  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum_nib[idx] <= rca_s;
          carry        <= rca_c[4];
          if (idx == IDXW'(NIB - 1)) begin
            sum_msb <= rca_c[4];
            idx     <= '0;
            done_q  <= 1'b1;
            state   <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = {sum_msb, sum_nib};

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed vectors plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rca_seq_ctrl_if #(.WIDTH(W)) bus ();

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1..NIB running, NIB+1 done.
  int     ph;
  longint full;
  longint m_sum;
  int     done_cnt;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input bit c, input bit sb);
    longint bb;
    longint cc;
    if (rst) begin
      ph    = 0;
      m_sum = 0;
    end else if (ph == 0) begin
      if (st) begin
        bb    = sb ? longint'(~bv) : longint'(bv);
        cc    = sb ? 1 : longint'(c);
        full  = (longint'(av) + bb + cc) & ((longint'(1) << (W + 1)) - 1);
        ph    = 1;
        m_sum = 0;
      end
    end else if (ph <= NIB) begin
      ph++;
      if (ph == NIB + 1) m_sum = full;
      else               m_sum = full & ((longint'(1) << (4 * (ph - 1))) - 1);
    end else begin
      ph = 0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
  task automatic cycle(input bit rst, input bit st, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit c, input bit sb);
    reset     = rst;
    bus.start = st;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = c;
`ifdef RCA_SEQ_SUB_EN
    bus.sub   = sb;
`endif
    @(posedge clk);
`ifdef RCA_SEQ_SUB_EN
    model_edge(rst, st, av, bv, c, sb);
`else
    model_edge(rst, st, av, bv, c, 1'b0);
`endif
    @(negedge clk);
    check("busy", longint'(bus.busy), longint'(ph != 0));
    check("done", longint'(bus.done), longint'(ph == NIB + 1));
    check("sum",  longint'(bus.sum),  m_sum);
    if (bus.done) done_cnt++;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
  endtask

  // Start one operation and step to its DONE cycle, then check the constant result.
  task automatic run_vec(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit c, input bit sb, input longint exp);
    cycle(1'b0, 1'b1, av, bv, c, sb);
    repeat (NIB) cycle(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    check({tag, "_done"}, longint'(bus.done), 1);
    check(tag, longint'(bus.sum), exp);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    ph       = 0;
    full     = 0;
    m_sum    = 0;
    done_cnt = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    bus.sub   = 1'b0;
`endif
    @(negedge clk);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) idle_cycle();
    check("rst_sum", longint'(bus.sum), 0);

    run_vec("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 64'h10000);
    idle_cycle();

    run_vec("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 64'h05556);
    repeat (10) idle_cycle();
    check("hold", longint'(bus.sum), 64'h05556);

    // Start held high: one accepted add per NIB+2 cycles.
    done_cnt = 0;
    repeat (3 * (NIB + 2)) cycle(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    check("held_start_dones", longint'(done_cnt), 3);
    idle_cycle();

    // Reset in cycle 3 of an add.
    cycle(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    check("mid_rst_busy", longint'(bus.busy), 0);
    check("mid_rst_sum", longint'(bus.sum), 0);
    run_vec("after_rst", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 64'h0FFFF);
    idle_cycle();

`ifdef RCA_SEQ_SUB_EN
    run_vec("sub_pos", 16'h0005, 16'h0003, 1'b0, 1'b1, 64'h10002);
    idle_cycle();
    run_vec("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 64'h0FFFE);
    idle_cycle();
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
            W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
